// File: rtl/tick_gen_pkg.sv
// Shared constants, helpers and channel state type for the tick_gen clock-enable generator.
`timescale 1ns/1ps
package tick_gen_pkg;

  localparam int          CNT_W_DEF     = 27;
  localparam int unsigned DEF_PERIOD_1K = 99_999;

  // Period register value that yields tick_hz strobes from a clk_hz clock.
  function automatic int unsigned hz_to_period(input int unsigned clk_hz,
                                               input int unsigned tick_hz);
    return (clk_hz / tick_hz) - 1;
  endfunction

  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [CNT_W_DEF-1:0] per;
    logic [CNT_W_DEF-1:0] shd;
    logic                 pend;
  } ch_state_t;

endpackage

// File: rtl/tick_gen_ch.sv
// One tick_gen channel: counter, shadow/active period, tick and optional square-wave output.
// Square wave is built only when TICK_GEN_SQUARE_EN is defined; otherwise sq is tied low.
`timescale 1ns/1ps
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_1K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] wval,
  output logic             tick,
  output logic             load_pend,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == per_q);

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tick_d = 1'b0;

    if (!en) begin
      cnt_d = '0;
      if (pend_q) begin
        per_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (sync) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (pend_q) begin
        per_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A write landing on a wrap edge goes straight into the active period.
    if (we) begin
      shd_d = wval;
      if (en && !sync && wrap) begin
        per_d  = wval;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      per_q  <= CNT_W'(DEF_PERIOD);
      shd_q  <= CNT_W'(DEF_PERIOD);
      pend_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign load_pend = pend_q;

`ifdef TICK_GEN_SQUARE_EN
  logic sq_q, sq_d;

  // Compare against next-state values so sq lines up with the registered counter.
  always_comb begin
    sq_d = en && !sync && (cnt_d <= (per_d >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator: period write decode and sync fan-out to N_CH channels.
// Optional square-wave outputs are enabled by defining TICK_GEN_SQUARE_EN.
`timescale 1ns/1ps
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter  int          N_CH       = 4,
  parameter  int          CNT_W      = CNT_W_DEF,
  parameter  int unsigned DEF_PERIOD = DEF_PERIOD_1K,
  localparam int          SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  load_pend,
  output logic [N_CH-1:0]  sq
);

  logic [N_CH-1:0] we_vec;

  // Out-of-range selects are dropped; compare at 32 bits so N_CH = 2^SEL_W is safe.
  always_comb begin
    we_vec = '0;
    if (div_we && (32'(div_sel) < 32'(N_CH))) begin
      for (int i = 0; i < N_CH; i++) begin
        if (div_sel == SEL_W'(i)) begin
          we_vec[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_gen_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[g]),
      .sync      (sync),
      .we        (we_vec[g]),
      .wval      (div_val),
      .tick      (tick[g]),
      .load_pend (load_pend[g]),
      .sq        (sq[g])
    );
  end

endmodule
